rvv_cmd_queue: RTL

Multi-entry circular FIFO between the RVV front end and the RVV backend dispatch. Each cycle it accepts up to N aligned RVVCmd entries from the front end and presents up to M oldest entries, in order, to the backend. It reports free capacity, saturated to 2*N, back to the front end for its backpressure calculation. A synchronous flush discards all contents on a trap.

---
 rtl/rvv_cmd_queue_pkg.sv | 41 ++++
 rtl/rvv_cmd_queue.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/rvv_cmd_queue_pkg.sv
// rvv_cmd_queue_pkg: shared RVV types used between the front end and the
// backend dispatch.
//   lmul_e / sew_e    vtype field encodings
//   RVVConfigState    vtype/vl snapshot that travels with each command
//   RVVInstruction    raw 32-bit vector instruction word
//   RVVCmd            one queued command: instruction, config and tag
package rvv_cmd_queue_pkg;

  typedef enum logic [2:0] {
    LMUL_1    = 3'd0,
    LMUL_2    = 3'd1,
    LMUL_4    = 3'd2,
    LMUL_8    = 3'd3,
    LMUL_RSVD = 3'd4,
    LMUL_F8   = 3'd5,
    LMUL_F4   = 3'd6,
    LMUL_F2   = 3'd7
  } lmul_e;

  typedef enum logic [1:0] {
    SEW_8  = 2'd0,
    SEW_16 = 2'd1,
    SEW_32 = 2'd2,
    SEW_64 = 2'd3
  } sew_e;

  typedef struct packed {
    lmul_e      lmul;
    sew_e       sew;
    logic [7:0] vl;
  } RVVConfigState;

  typedef logic [31:0] RVVInstruction;

  typedef struct packed {
    RVVInstruction insn;
    RVVConfigState cfg;
    logic [7:0]    tag;
  } RVVCmd;

endpackage

// File: rtl/rvv_cmd_queue.sv
// rvv_cmd_queue: multi-entry circular FIFO between the RVV front end and the
// backend dispatch. Accepts up to N aligned commands per cycle, presents the
// M oldest entries in order, reports saturated free capacity.
//   clk, rstn          clock, asynchronous active-low reset
//   cmd_valid_i/data_i enqueue lanes (prefix-contiguous valids, no ready)
//   queue_capacity_o   min(DEPTH - count, 2*N), from registered count only
//   deq_valid_o/data_o oldest M entries, lane j = j-th oldest
//   deq_ready_i        per-lane accept; pops stop at the first refused lane
//   flush_i            synchronous drop of all entries
//   overflow_o         sticky, set when an enqueue exceeds free space
// Optional build macro RVV_CMD_QUEUE_STATS_EN adds hwm_o, the high-water mark
// of the occupancy since reset (not cleared by flush).
module rvv_cmd_queue
  import rvv_cmd_queue_pkg::*;
#(
  parameter int unsigned N            = 4,
  parameter int unsigned M            = 2,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned CAPACITYBITS = $clog2(2*N+1)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [N-1:0]            cmd_valid_i,
  input  RVVCmd [N-1:0]           cmd_data_i,
  output logic [CAPACITYBITS-1:0] queue_capacity_o,
  output logic [M-1:0]            deq_valid_o,
  output RVVCmd [M-1:0]           deq_data_o,
  input  logic [M-1:0]            deq_ready_i,
  input  logic                    flush_i,
  output logic                    overflow_o
`ifdef RVV_CMD_QUEUE_STATS_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] hwm_o
`endif
);

  localparam int unsigned PTRW = $clog2(DEPTH);
  localparam int unsigned CNTW = $clog2(DEPTH+1);
  localparam int unsigned ENQW = $clog2(N+1);
  localparam int unsigned DEQW = $clog2(M+1);

  if (M == 0 || M > N) begin : g_bad_m
    $error("rvv_cmd_queue: M must satisfy 1 <= M <= N");
  end
  if (DEPTH < 2*N || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rvv_cmd_queue: DEPTH must be a power of two and >= 2*N");
  end

  logic [PTRW-1:0] rd_ptr;
  logic [PTRW-1:0] wr_ptr;
  logic [CNTW-1:0] count;
  logic [CNTW-1:0] count_nxt;
  RVVCmd           mem [DEPTH];

  logic [ENQW-1:0] enq_cnt;
  logic [DEQW-1:0] deq_cnt;
  logic [CNTW:0]   room;
  logic            enq_over;
  logic            enq_ok;
  logic            run;

  always_comb begin
    enq_cnt = '0;
    for (int unsigned i = 0; i < N; i++) begin
      enq_cnt = enq_cnt + ENQW'(cmd_valid_i[i]);
    end
  end

  always_comb begin
    deq_valid_o = '0;
    for (int unsigned j = 0; j < M; j++) begin
      deq_valid_o[j] = CNTW'(j) < count;
      deq_data_o[j]  = mem[rd_ptr + PTRW'(j)];
    end
  end

  // Pops count leading accepted lanes only; a ready after a gap is ignored.
  always_comb begin
    deq_cnt = '0;
    run     = 1'b1;
    for (int unsigned j = 0; j < M; j++) begin
      if (run && deq_valid_o[j] && deq_ready_i[j]) begin
        deq_cnt = deq_cnt + 1'b1;
      end else begin
        run = 1'b0;
      end
    end
  end

  // Slots freed by this cycle's pops count toward room for this cycle's write.
  always_comb begin
    room      = (CNTW+1)'(DEPTH) - (CNTW+1)'(count) + (CNTW+1)'(deq_cnt);
    enq_over  = (CNTW+1)'(enq_cnt) > room;
    enq_ok    = !enq_over && !flush_i;
    count_nxt = '0;
    if (!flush_i) begin
      count_nxt = count + (enq_ok ? CNTW'(enq_cnt) : '0) - CNTW'(deq_cnt);
    end
  end

  always_comb begin
    if (count <= CNTW'(DEPTH - 2*N)) begin
      queue_capacity_o = CAPACITYBITS'(2*N);
    end else begin
      queue_capacity_o = CAPACITYBITS'(CNTW'(DEPTH) - count);
    end
  end

  always_ff @(posedge clk) begin
    if (enq_ok) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (cmd_valid_i[i]) begin
          mem[wr_ptr + PTRW'(i)] <= cmd_data_i[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (enq_over) begin
        overflow_o <= 1'b1;
      end
      count <= count_nxt;
      if (flush_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        rd_ptr <= rd_ptr + PTRW'(deq_cnt);
        if (enq_ok) begin
          wr_ptr <= wr_ptr + PTRW'(enq_cnt);
        end
      end
    end
  end

`ifdef RVV_CMD_QUEUE_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hwm_o <= '0;
    end else if (count_nxt > hwm_o) begin
      hwm_o <= count_nxt;
    end
  end
`endif

endmodule
